// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer and a buffered output.
// Define UART_RX_FIFO_EN to use a FIFO_DEPTH-entry FWFT FIFO; otherwise a single holding register.
module uart_rx #(
    parameter int CLKS_PER_BIT = 68,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_rx: CLKS_PER_BIT or FIFO_DEPTH out of range");
    end

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        rx_meta;
    logic        rx_s;
    logic        rx_prev;
    logic        stop_done;
    logic        deliver;
    logic        accept;

    assign stop_done = (state == STOP) && (cnt == BIT_LAST);
    assign deliver   = stop_done && rx_s;
    assign accept    = rx_valid && rx_ready;

    // Receive FSM; rx_prev makes a held-low line wait for a fresh falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop here sample pre-edge values, so
            // the synchronizer chain and FSM behave as registers regardless of statement order.
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            rx_prev   <= rx_s;
            frame_err <= stop_done && !rx_s;
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) state <= STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0]     mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic [PTR_W:0] used;
    logic           full;
    logic           push;

    // Extra pointer bit separates full from empty when the index bits match.
    assign used     = wr_ptr - rd_ptr;
    assign full     = (used == (PTR_W + 1)'(FIFO_DEPTH));
    assign push     = deliver && (!full || accept);
    assign rx_valid = (wr_ptr != rd_ptr);
    assign rx_data  = rx_valid ? mem[rd_ptr[PTR_W-1:0]] : 8'h00;

    // NOTE: the storage array has no reset; rx_data is masked while empty, so stale
    // entries are never visible and the array can map onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= deliver && !push;
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (accept) rd_ptr <= rd_ptr + 1'b1;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver && (!rx_valid || accept)) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else begin
                if (accept)  rx_valid <= 1'b0;
                if (deliver) overrun  <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx against a byte-queue reference model.
// Works with or without UART_RX_FIFO_EN defined.
module tb_uart_rx;
    localparam int CPB = 16;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    byte unsigned got_q[$];
    byte unsigned exp_q[$];
    int fe_cnt = 0, ov_cnt = 0, fe_wide = 0, ov_wide = 0, vcyc = 0;
    int exp_fe = 0, exp_ov = 0;
    logic fe_prev = 1'b0, ov_prev = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are stable at the falling edge; a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rx_valid) vcyc++;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (frame_err) fe_cnt++;
        if (frame_err && fe_prev) fe_wide++;
        if (overrun) ov_cnt++;
        if (overrun && ov_prev) ov_wide++;
        fe_prev = frame_err;
        ov_prev = overrun;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a good frame lands in the buffer if there is room, else counts an overrun.
    task automatic model(input logic [7:0] b, input logic stop);
        int held;
        held = exp_q.size() - got_q.size();
        if (!stop) exp_fe++;
        else if (rx_ready || held < CAP) exp_q.push_back(b);
        else exp_ov++;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        model(b, stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
        tick(2 * CPB);
    endtask

    task automatic drain_check(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_byte"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int v0;
        int n;
        logic [7:0] b;
        logic stop;

        tick(3);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        rst_n = 1'b1;
        tick(3 * CPB);

        // Basic byte with consumer always ready
        rx_ready = 1'b1;
        v0 = vcyc;
        send(8'hA5, 1'b1);
        check("a5_valid_cycles", vcyc - v0, 1);
        drain_check("a5");
        check("a5_frame_err", fe_cnt, exp_fe);

        // Short low glitch must be rejected
        v0 = vcyc;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(3 * CPB);
        check("glitch_valid_cycles", vcyc - v0, 0);
        check("glitch_frame_err", fe_cnt, exp_fe);

        // Bad stop bit, then the same byte framed correctly
        v0 = vcyc;
        send(8'h3C, 1'b0);
        check("badstop_valid_cycles", vcyc - v0, 0);
        check("badstop_frame_err", fe_cnt, exp_fe);
        send(8'h3C, 1'b1);
        drain_check("goodstop");

        // Fill the buffer with the consumer stalled
        rx_ready = 1'b0;
`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
`else
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
`endif
        check("fill_overrun", ov_cnt, exp_ov);
        check("fill_valid", rx_valid, 1'b1);
        check("fill_head", rx_data, exp_q[0]);
        rx_ready = 1'b1;
        tick(CAP + 4);
        drain_check("fill_drain");
        check("fill_empty", rx_valid, 1'b0);

        // Random bytes, occasionally with a bad stop bit
        for (int k = 0; k < 10; k++) begin
            b = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send(b, stop);
        end
        drain_check("rand");
        check("rand_frame_err", fe_cnt, exp_fe);

        // Random overflow burst
        rx_ready = 1'b0;
        n = CAP + 1 + int'($urandom_range(0, 1));
        for (int k = 0; k < n; k++) send(8'($urandom_range(0, 255)), 1'b1);
        check("burst_overrun", ov_cnt, exp_ov);
        check("burst_head", rx_data, exp_q[0]);
        rx_ready = 1'b1;
        tick(CAP + 4);
        drain_check("burst_drain");

        // Reset in the middle of data bit 3 of 0x77 with a byte already buffered
        rx_ready = 1'b0;
        send(8'h33, 1'b1);
        check("pre_reset_valid", rx_valid, 1'b1);
        b = 8'h77;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = b[3];
        tick(CPB / 2);
        rst_n = 1'b0;
        #1;
        check("midreset_rx_data", rx_data, 8'h00);
        check("midreset_rx_valid", rx_valid, 1'b0);
        check("midreset_frame_err", frame_err, 1'b0);
        check("midreset_overrun", overrun, 1'b0);
        got_q.delete();
        exp_q.delete();
        rx = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(2 * CPB);
        check("postreset_valid", rx_valid, 1'b0);
        check("postreset_frame_err", fe_cnt, exp_fe);
        check("postreset_overrun", ov_cnt, exp_ov);
        rx_ready = 1'b1;
        send(8'h5A, 1'b1);
        drain_check("after_reset");

        check("frame_err_width", fe_wide, 0);
        check("overrun_width", ov_wide, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
